// File: rtl/uart_sfr_pkg.sv
// Shared definitions for the UART SFR bridge.
//   - register address map for the 2-bit peripheral bus address
//   - STATUS register bit positions
//   - default prescale (125 MHz / (9600 * 8))
package uart_sfr_pkg;

   localparam logic [1:0] UART_REG_DATA     = 2'd0;
   localparam logic [1:0] UART_REG_STATUS   = 2'd1;
   localparam logic [1:0] UART_REG_PRESC_LO = 2'd2;
   localparam logic [1:0] UART_REG_PRESC_HI = 2'd3;

   localparam int unsigned STAT_RX_AVAIL = 0;
   localparam int unsigned STAT_TX_FULL  = 1;
   localparam int unsigned STAT_TX_EMPTY = 2;
   localparam int unsigned STAT_TX_IDLE  = 3;
   localparam int unsigned STAT_RX_OVR   = 4;
   localparam int unsigned STAT_RX_FRM   = 5;
   localparam int unsigned STAT_TX_OVF   = 6;
   localparam int unsigned STAT_IE       = 7;

   localparam logic [15:0] UART_PRESCALE_DEFAULT = 16'd1628;

endpackage

// File: rtl/uart_sfr_fifo.sv
// Small synchronous FIFO used for both the TX and RX byte buffers.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_data     write request and data
//   pop                 read request (ignored while empty)
//   head                oldest entry (0 while empty after reset)
//   full, empty         occupancy flags
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module uart_sfr_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      cnt;
   logic             push_ok, pop_ok;

   assign full    = (cnt == CNT_FULL);
   assign empty   = (cnt == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + CNT_ONE;
            2'b01:   cnt <= cnt - CNT_ONE;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/uart_sfr_bridge.sv
// Register-mapped bridge between the core peripheral bus and an AXI4-Stream UART.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   addr, wdata, we, re, rdata    SFR bus (DATA / STATUS / PRESC_LO / PRESC_HI)
//   irq                           registered interrupt request
//   m_axis_*                      TX stream into the UART
//   s_axis_*                      RX stream out of the UART
//   tx_busy, rx_overrun_error,
//   rx_frame_error                UART status (errors are 1-cycle pulses)
//   prescale                      UART bit-rate prescale
module uart_sfr_bridge
   import uart_sfr_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter logic [15:0] PRESCALE_RESET = UART_PRESCALE_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  addr,
   input  logic [7:0]  wdata,
   input  logic        we,
   input  logic        re,
   output logic [7:0]  rdata,
   output logic        irq,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        tx_busy,
   input  logic        rx_overrun_error,
   input  logic        rx_frame_error,
   output logic [15:0] prescale
);

   logic       tx_full, tx_empty, tx_push, tx_pop;
   logic       rx_full, rx_empty, rx_push, rx_pop;
   logic [7:0] rx_head;
   logic       rx_ovr, rx_frm, tx_ovf, ie;
   logic       wr_data, wr_status;
   logic [7:0] status;

   assign wr_data   = we && (addr == UART_REG_DATA);
   assign wr_status = we && (addr == UART_REG_STATUS);

   assign tx_push = wr_data;
   assign tx_pop  = m_axis_tvalid && m_axis_tready;
   assign rx_pop  = re && (addr == UART_REG_DATA);
   // Ready stays up while full if a bus pop frees a slot this same cycle.
   assign s_axis_tready = !rx_full || (rx_pop && !rx_empty);
   assign rx_push = s_axis_tvalid && s_axis_tready;
   assign m_axis_tvalid = !tx_empty;

   uart_sfr_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst),
      .push(tx_push), .push_data(wdata), .pop(tx_pop),
      .head(m_axis_tdata), .full(tx_full), .empty(tx_empty)
   );

   uart_sfr_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst),
      .push(rx_push), .push_data(s_axis_tdata), .pop(rx_pop),
      .head(rx_head), .full(rx_full), .empty(rx_empty)
   );

   always_comb begin
      status                = '0;
      status[STAT_RX_AVAIL] = !rx_empty;
      status[STAT_TX_FULL]  = tx_full;
      status[STAT_TX_EMPTY] = tx_empty;
      status[STAT_TX_IDLE]  = tx_empty && !tx_busy;
      status[STAT_RX_OVR]   = rx_ovr;
      status[STAT_RX_FRM]   = rx_frm;
      status[STAT_TX_OVF]   = tx_ovf;
      status[STAT_IE]       = ie;
   end

   always_comb begin
      rdata = '0;
      case (addr)
         UART_REG_DATA:     rdata = rx_empty ? 8'h00 : rx_head;
         UART_REG_STATUS:   rdata = status;
         UART_REG_PRESC_LO: rdata = prescale[7:0];
         UART_REG_PRESC_HI: rdata = prescale[15:8];
         default:           rdata = '0;
      endcase
   end

   // Sticky flags: clear first, then set, so a same-cycle set wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_ovr   <= 1'b0;
         rx_frm   <= 1'b0;
         tx_ovf   <= 1'b0;
         ie       <= 1'b0;
         irq      <= 1'b0;
         prescale <= PRESCALE_RESET;
      end else begin
         rx_ovr <= (rx_ovr && !(wr_status && wdata[STAT_RX_OVR])) || rx_overrun_error;
         rx_frm <= (rx_frm && !(wr_status && wdata[STAT_RX_FRM])) || rx_frame_error;
         tx_ovf <= (tx_ovf && !(wr_status && wdata[STAT_TX_OVF]))
                   || (tx_push && tx_full && !tx_pop);
         if (wr_status) ie <= wdata[STAT_IE];
         irq <= ie && (!rx_empty || rx_ovr || rx_frm || tx_ovf);
         if (we && (addr == UART_REG_PRESC_LO)) prescale[7:0]  <= wdata;
         if (we && (addr == UART_REG_PRESC_HI)) prescale[15:8] <= wdata;
      end
   end

endmodule

// File: tb/tb_uart_sfr_bridge.sv
module tb_uart_sfr_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  addr;
   logic [7:0]  wdata;
   logic        we, re;
   logic [7:0]  rdata;
   logic        irq;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tready;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tvalid, s_axis_tready;
   logic        tx_busy, rx_overrun_error, rx_frame_error;
   logic [15:0] prescale;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [7:0]  rd;

   uart_sfr_bridge #(.FIFO_DEPTH(4), .PRESCALE_RESET(16'd1628)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
      .rdata(rdata), .irq(irq),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .tx_busy(tx_busy), .rx_overrun_error(rx_overrun_error),
      .rx_frame_error(rx_frame_error), .prescale(prescale)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      addr = a; wdata = d; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      addr = a; re = 1'b1;
      #1 d = rdata;
      tick();
      re = 1'b0;
   endtask

   initial begin
      rst = 1'b1; addr = 2'd0; wdata = '0; we = 1'b0; re = 1'b0;
      m_axis_tready = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
      tx_busy = 1'b0; rx_overrun_error = 1'b0; rx_frame_error = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // Reset mid-transfer: TX holds a byte, UART reports busy.
      bus_write(2'd0, 8'hAB);
      check("pre_rst_tvalid", 16'(m_axis_tvalid), 16'h1);
      bus_write(2'd2, 8'h77);
      tx_busy = 1'b1;
      rst = 1'b1;
      addr = 2'd1;
      #1;
      check("rst_prescale", prescale, 16'd1628);
      check("rst_status", 16'(rdata), 16'h04);
      check("rst_irq", 16'(irq), 16'h0);
      check("rst_tvalid", 16'(m_axis_tvalid), 16'h0);
      check("rst_tdata", 16'(m_axis_tdata), 16'h0);
      check("rst_tready", 16'(s_axis_tready), 16'h1);
      tick();
      rst = 1'b0;
      tx_busy = 1'b0;
      tick();

      // TX order and overflow
      bus_write(2'd0, 8'h55);
      check("tx_tvalid_1cyc", 16'(m_axis_tvalid), 16'h1);
      bus_write(2'd0, 8'hAA);
      bus_write(2'd0, 8'h01);
      bus_read(2'd1, rd);
      check("tx_not_full_3", 16'(rd[1]), 16'h0);
      bus_write(2'd0, 8'h02);
      bus_read(2'd1, rd);
      check("tx_full_4", 16'(rd[1]), 16'h1);
      bus_write(2'd0, 8'h03);
      bus_read(2'd1, rd);
      check("tx_ovf_set", 16'(rd[6]), 16'h1);
      check("tx_head_stable", 16'(m_axis_tdata), 16'h55);
      m_axis_tready = 1'b1;
      begin
         logic [7:0] exp_tx [4];
         exp_tx[0] = 8'h55; exp_tx[1] = 8'hAA; exp_tx[2] = 8'h01; exp_tx[3] = 8'h02;
         for (int i = 0; i < 4; i++) begin
            check($sformatf("tx_valid_%0d", i), 16'(m_axis_tvalid), 16'h1);
            check($sformatf("tx_data_%0d", i), 16'(m_axis_tdata), 16'(exp_tx[i]));
            tick();
         end
      end
      m_axis_tready = 1'b0;
      check("tx_drained_valid", 16'(m_axis_tvalid), 16'h0);
      bus_read(2'd1, rd);
      check("tx_empty_idle", 16'(rd), 16'h4C);
      bus_write(2'd1, 8'h40);
      bus_read(2'd1, rd);
      check("tx_ovf_w1c", 16'(rd[6]), 16'h0);

      // RX backpressure
      for (int i = 0; i < 5; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 8'h10 + 8'(i);
         #1;
         check($sformatf("rx_tready_%0d", i), 16'(s_axis_tready), (i < 4) ? 16'h1 : 16'h0);
         tick();
      end
      s_axis_tvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus_read(2'd0, rd);
         check($sformatf("rx_data_%0d", i), 16'(rd), 16'h10 + 16'(i));
      end
      bus_read(2'd0, rd);
      check("rx_empty_data", 16'(rd), 16'h00);
      bus_read(2'd1, rd);
      check("rx_avail_clr", 16'(rd[0]), 16'h0);
      check("rx_tready_back", 16'(s_axis_tready), 16'h1);

      // Same-cycle push/pop with the RX FIFO full
      for (int i = 0; i < 4; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 8'h20 + 8'(i);
         tick();
      end
      s_axis_tdata = 8'h24;
      #1;
      check("pp_full_tready", 16'(s_axis_tready), 16'h0);
      addr = 2'd0; re = 1'b1;
      #1;
      check("pp_tready_on_pop", 16'(s_axis_tready), 16'h1);
      check("pp_rdata", 16'(rdata), 16'h20);
      tick();
      re = 1'b0; s_axis_tvalid = 1'b0;
      #1;
      check("pp_still_full", 16'(s_axis_tready), 16'h0);
      for (int i = 0; i < 4; i++) begin
         bus_read(2'd0, rd);
         check($sformatf("pp_data_%0d", i), 16'(rd), 16'h21 + 16'(i));
      end
      bus_read(2'd0, rd);
      check("pp_empty", 16'(rd), 16'h00);

      // Sticky flags and interrupt
      bus_write(2'd1, 8'h80);
      check("irq_idle", 16'(irq), 16'h0);
      rx_frame_error = 1'b1;
      tick();
      rx_frame_error = 1'b0;
      addr = 2'd1;
      #1;
      check("frm_set", 16'(rdata[5]), 16'h1);
      check("irq_lat_1", 16'(irq), 16'h0);
      tick();
      check("irq_lat_2", 16'(irq), 16'h1);
      addr = 2'd1; wdata = 8'hA0; we = 1'b1; rx_frame_error = 1'b1;
      tick();
      we = 1'b0; rx_frame_error = 1'b0;
      #1;
      check("frm_set_wins", 16'(rdata[5]), 16'h1);
      check("ie_kept", 16'(rdata[7]), 16'h1);
      bus_write(2'd1, 8'hA0);
      addr = 2'd1;
      #1;
      check("frm_w1c", 16'(rdata[5]), 16'h0);
      tick();
      check("irq_drop", 16'(irq), 16'h0);
      rx_overrun_error = 1'b1;
      tick();
      rx_overrun_error = 1'b0;
      #1;
      check("ovr_set", 16'(rdata), 16'h9C);
      bus_write(2'd1, 8'h10);
      addr = 2'd1;
      #1;
      check("ovr_w1c_ie_off", 16'(rdata), 16'h0C);
      tick();
      check("irq_ie_off", 16'(irq), 16'h0);

      // Prescale
      bus_write(2'd2, 8'h34);
      check("presc_lo_only", prescale, 16'h0634);
      bus_write(2'd3, 8'h12);
      check("presc_full", prescale, 16'h1234);
      bus_read(2'd2, rd);
      check("presc_lo_rd", 16'(rd), 16'h34);
      bus_read(2'd3, rd);
      check("presc_hi_rd", 16'(rd), 16'h12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
